// File: rtl/pc_pkg.sv
// Shared encodings and default vectors for the fetch-stage PC sequencer.
package pc_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    typedef enum logic [2:0] {
        SEL_INC,
        SEL_HOLD,
        SEL_BR,
        SEL_J,
        SEL_EXC
    } pc_sel_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
    localparam int          DEF_INC          = 4;
    localparam int          DEF_FLUSH_CYCLES = 1;
    localparam int          FLUSH_CNT_W      = 3;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/target inputs and PC outputs between hazard logic, the sequencer and imem.
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             Stall;
    logic             BranchTaken;
    logic [WIDTH-1:0] BranchTarget;
    logic             Jump;
    logic [WIDTH-1:0] JumpTarget;
    logic             Exception;
    logic             Halt;
    logic [WIDTH-1:0] PCResult;
    logic [WIDTH-1:0] PCAddResult;
    logic             Flush;
    logic             Valid;
    logic             Misaligned;

    modport master (
        output Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Exception, Halt,
        input  PCResult, PCAddResult, Flush, Valid, Misaligned
    );

    modport slave (
        input  Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Exception, Halt,
        output PCResult, PCAddResult, Flush, Valid, Misaligned
    );
endinterface

// File: rtl/pc_next_mux.sv
// Priority next-PC select (Exception > Branch > Jump > Stall > +INC), combinational.
// Misaligned branch/jump targets are replaced by the exception vector.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               INC        = DEF_INC,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic [WIDTH-1:0] pc_i,
    input  logic             stall_i,
    input  logic             br_i,
    input  logic [WIDTH-1:0] br_tgt_i,
    input  logic             j_i,
    input  logic [WIDTH-1:0] j_tgt_i,
    input  logic             exc_i,
    output logic [WIDTH-1:0] next_pc_o,
    output logic             redirect_o,
    output logic             misaligned_o
);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
    localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);

    pc_sel_e          sel;
    logic [WIDTH-1:0] tgt;

    always_comb begin
        sel = SEL_INC;
        if (exc_i)        sel = SEL_EXC;
        else if (br_i)    sel = SEL_BR;
        else if (j_i)     sel = SEL_J;
        else if (stall_i) sel = SEL_HOLD;
    end

    always_comb begin
        tgt          = (sel == SEL_BR) ? br_tgt_i : j_tgt_i;
        misaligned_o = 1'b0;
        redirect_o   = 1'b0;
        next_pc_o    = pc_i;
        case (sel)
            SEL_INC:  next_pc_o = pc_i + INC_W;
            SEL_HOLD: next_pc_o = pc_i;
            SEL_EXC: begin
                redirect_o = 1'b1;
                next_pc_o  = EXC_VECTOR;
            end
            SEL_BR, SEL_J: begin
                redirect_o   = 1'b1;
                misaligned_o = |(tgt & ALIGN_MASK);
                next_pc_o    = misaligned_o ? EXC_VECTOR : tgt;
            end
            default: next_pc_o = pc_i;
        endcase
    end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with redirect flush window and halt state; PC updates one edge
// after the selecting input, PCAddResult is combinational from the PC register.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               INC          = DEF_INC,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int               FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input logic           Clk,
    input logic           Reset,
    pc_sequencer_if.slave bus
);
    localparam logic [FLUSH_CNT_W-1:0] CNT_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    logic [WIDTH-1:0]       pc_q, pc_d;
    logic [1:0]             state_q, state_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic                   mis_q, mis_d;

    logic                   halted;
    logic [WIDTH-1:0]       next_pc;
    logic                   redirect;
    logic                   tgt_mis;

    assign halted = (state_q == ST_HALT);

    // While halted only Exception may move the PC; Halt itself acts as a hold.
    pc_next_mux #(
        .WIDTH      (WIDTH),
        .INC        (INC),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_mux (
        .pc_i         (pc_q),
        .stall_i      (bus.Stall | bus.Halt | halted),
        .br_i         (bus.BranchTaken & ~halted),
        .br_tgt_i     (bus.BranchTarget),
        .j_i          (bus.Jump & ~halted),
        .j_tgt_i      (bus.JumpTarget),
        .exc_i        (bus.Exception),
        .next_pc_o    (next_pc),
        .redirect_o   (redirect),
        .misaligned_o (tgt_mis)
    );

    always_comb begin
        pc_d    = next_pc;
        state_d = state_q;
        cnt_d   = cnt_q;
        mis_d   = redirect & tgt_mis;
        if (redirect) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_LOAD;
        end else if (halted) begin
            state_d = ST_HALT;
        end else if (bus.Halt) begin
            state_d = ST_HALT;
            cnt_d   = '0;
        end else if (state_q == ST_FLUSH) begin
            if (cnt_q == '0) state_d = ST_RUN;
            else             cnt_d   = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q    <= RESET_VECTOR;
            state_q <= ST_RUN;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.PCResult    = pc_q;
    assign bus.PCAddResult = pc_q + WIDTH'(INC);
    assign bus.Flush       = (state_q == ST_FLUSH);
    assign bus.Valid       = (state_q == ST_RUN);
    assign bus.Misaligned  = mis_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, async-reset sequences, random vs reference model.
module tb_pc_sequencer;
    localparam logic [31:0] EXC = 32'h8000_0180;

    typedef struct {
        logic        stall, br, j, exc, halt;
        logic [31:0] bt, jt;
    } in_t;

    typedef struct {
        in_t         in;
        logic [31:0] pc;
        logic        fl, v, mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        int          flush_left;
        bit          halted;
        bit          mis;
    } mdl_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        stall, br, j, exc, halt;
    logic [31:0] bt, jt;

    int checks   = 0;
    int failures = 0;

    mdl_t m1, m3;
    vec_t tbl[30];

    always #5 Clk = ~Clk;

    pc_sequencer_if #(.WIDTH(32)) if1 ();
    pc_sequencer_if #(.WIDTH(32)) if3 ();

    assign if1.Stall = stall;  assign if1.BranchTaken = br;  assign if1.BranchTarget = bt;
    assign if1.Jump  = j;      assign if1.JumpTarget  = jt;  assign if1.Exception    = exc;
    assign if1.Halt  = halt;
    assign if3.Stall = stall;  assign if3.BranchTaken = br;  assign if3.BranchTarget = bt;
    assign if3.Jump  = j;      assign if3.JumpTarget  = jt;  assign if3.Exception    = exc;
    assign if3.Halt  = halt;

    pc_sequencer #(
        .WIDTH(32), .INC(4), .RESET_VECTOR(32'h0), .EXC_VECTOR(EXC), .FLUSH_CYCLES(1)
    ) u_dut1 (.Clk(Clk), .Reset(Reset), .bus(if1));

    pc_sequencer #(
        .WIDTH(32), .INC(4), .RESET_VECTOR(32'h0), .EXC_VECTOR(EXC), .FLUSH_CYCLES(3)
    ) u_dut3 (.Clk(Clk), .Reset(Reset), .bus(if3));

    function automatic in_t mk_in(logic s, logic b, logic [31:0] btv, logic jj,
                                  logic [31:0] jtv, logic e, logic h);
        in_t i;
        i.stall = s; i.br = b; i.bt = btv; i.j = jj; i.jt = jtv; i.exc = e; i.halt = h;
        return i;
    endfunction

    function automatic vec_t mk(in_t i, logic [31:0] pc, logic fl, logic v, logic mis);
        vec_t r;
        r.in = i; r.pc = pc; r.fl = fl; r.v = v; r.mis = mis;
        return r;
    endfunction

    function automatic mdl_t mreset();
        mdl_t m;
        m.pc = 32'h0; m.flush_left = 0; m.halted = 0; m.mis = 0;
        return m;
    endfunction

    // Reference: flush_left counts remaining flush cycles; halted is a plain flag.
    function automatic mdl_t mstep(mdl_t m, in_t i, int fc);
        mdl_t        n = m;
        logic [31:0] tgt;
        n.mis = 0;
        if (i.exc || (!m.halted && (i.br || i.j))) begin
            if (i.exc) tgt = EXC;
            else begin
                tgt = i.br ? i.bt : i.jt;
                if (tgt % 4 != 0) begin
                    tgt   = EXC;
                    n.mis = 1;
                end
            end
            n.pc = tgt; n.flush_left = fc; n.halted = 0;
        end else if (m.halted) begin
            n.pc = m.pc;
        end else if (i.halt) begin
            n.halted = 1; n.flush_left = 0;
        end else begin
            if (n.flush_left > 0) n.flush_left--;
            if (!i.stall) n.pc = m.pc + 32'd4;
        end
        return n;
    endfunction

    task automatic drive(in_t i);
        stall = i.stall; br = i.br; bt = i.bt; j = i.j; jt = i.jt; exc = i.exc; halt = i.halt;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_mdl(string tag, mdl_t m, logic [31:0] pc, logic [31:0] pca,
                           logic fl, logic v, logic mis);
        chk({tag, ".pc"},    pc,  m.pc);
        chk({tag, ".pcadd"}, pca, m.pc + 32'd4);
        chk({tag, ".flush"}, 32'(fl),  32'(m.flush_left > 0));
        chk({tag, ".valid"}, 32'(v),   32'(!m.halted && m.flush_left == 0));
        chk({tag, ".mis"},   32'(mis), 32'(m.mis));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive(mk_in(0, 0, 0, 0, 0, 0, 0));
        @(posedge Clk);
        #1 Reset = 1'b0;
        m1 = mreset();
        m3 = mreset();
    endtask

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] r = $urandom;
        if ($urandom_range(3) != 0) r[1:0] = 2'b00;
        return r;
    endfunction

    initial begin
        in_t idle, ri;
        idle = mk_in(0, 0, 0, 0, 0, 0, 0);

        tbl[0]  = mk(idle, 32'h4, 0, 1, 0);
        tbl[1]  = mk(idle, 32'h8, 0, 1, 0);
        tbl[2]  = mk(idle, 32'hC, 0, 1, 0);
        tbl[3]  = mk(idle, 32'h10, 0, 1, 0);
        tbl[4]  = mk(mk_in(1, 0, 0, 0, 0, 0, 0), 32'h10, 0, 1, 0);
        tbl[5]  = mk(mk_in(1, 0, 0, 0, 0, 0, 0), 32'h10, 0, 1, 0);
        tbl[6]  = mk(idle, 32'h14, 0, 1, 0);
        tbl[7]  = mk(idle, 32'h18, 0, 1, 0);
        tbl[8]  = mk(idle, 32'h1C, 0, 1, 0);
        tbl[9]  = mk(idle, 32'h20, 0, 1, 0);
        tbl[10] = mk(mk_in(1, 1, 32'h100, 1, 32'h200, 0, 0), 32'h100, 1, 0, 0);
        tbl[11] = mk(idle, 32'h104, 0, 1, 0);
        tbl[12] = mk(mk_in(0, 0, 0, 1, 32'h202, 0, 0), EXC, 1, 0, 1);
        tbl[13] = mk(mk_in(0, 1, 32'h3C, 0, 0, 0, 0), 32'h3C, 1, 0, 0);
        tbl[14] = mk(idle, 32'h40, 0, 1, 0);
        tbl[15] = mk(mk_in(0, 0, 0, 0, 0, 0, 1), 32'h40, 0, 0, 0);
        tbl[16] = mk(mk_in(0, 0, 0, 1, 32'h300, 0, 0), 32'h40, 0, 0, 0);
        tbl[17] = mk(mk_in(0, 1, 32'h400, 0, 0, 0, 0), 32'h40, 0, 0, 0);
        tbl[18] = mk(mk_in(1, 0, 0, 1, 32'h300, 0, 0), 32'h40, 0, 0, 0);
        tbl[19] = mk(mk_in(0, 0, 0, 1, 32'h300, 0, 0), 32'h40, 0, 0, 0);
        tbl[20] = mk(mk_in(0, 0, 0, 1, 32'h300, 0, 0), 32'h40, 0, 0, 0);
        tbl[21] = mk(mk_in(0, 0, 0, 0, 0, 1, 0), EXC, 1, 0, 0);
        tbl[22] = mk(idle, EXC + 32'd4, 0, 1, 0);
        tbl[23] = mk(mk_in(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0), 32'hFFFF_FFFC, 1, 0, 0);
        tbl[24] = mk(idle, 32'h0, 0, 1, 0);
        tbl[25] = mk(mk_in(0, 1, 32'h500, 0, 0, 0, 1), 32'h500, 1, 0, 0);
        tbl[26] = mk(idle, 32'h504, 0, 1, 0);
        tbl[27] = mk(mk_in(1, 1, 32'h601, 0, 0, 1, 0), EXC, 1, 0, 0);
        tbl[28] = mk(mk_in(0, 1, 32'h1001, 0, 0, 0, 0), EXC, 1, 0, 1);
        tbl[29] = mk(idle, EXC + 32'd4, 0, 1, 0);

        do_reset();
        chk("rst.pc",    if1.PCResult, 32'h0);
        chk("rst.pcadd", if1.PCAddResult, 32'h4);
        chk("rst.flush", 32'(if1.Flush), 32'h0);
        chk("rst.valid", 32'(if1.Valid), 32'h1);
        chk("rst.mis",   32'(if1.Misaligned), 32'h0);

        for (int k = 0; k < 30; k++) begin
            drive(tbl[k].in);
            @(posedge Clk);
            #1;
            m3 = mstep(m3, tbl[k].in, 3);
            chk($sformatf("vec%0d.pc", k),    if1.PCResult, tbl[k].pc);
            chk($sformatf("vec%0d.pcadd", k), if1.PCAddResult, tbl[k].pc + 32'd4);
            chk($sformatf("vec%0d.flush", k), 32'(if1.Flush), 32'(tbl[k].fl));
            chk($sformatf("vec%0d.valid", k), 32'(if1.Valid), 32'(tbl[k].v));
            chk($sformatf("vec%0d.mis", k),   32'(if1.Misaligned), 32'(tbl[k].mis));
            chk_mdl($sformatf("vec%0d.d3", k), m3, if3.PCResult, if3.PCAddResult,
                    if3.Flush, if3.Valid, if3.Misaligned);
        end

        // Asynchronous reset in the middle of a 3-cycle flush window.
        do_reset();
        drive(mk_in(0, 1, 32'h200, 0, 0, 0, 0));
        @(posedge Clk);
        #1 drive(idle);
        @(posedge Clk);
        #1;
        chk("midflush.pre_flush", 32'(if3.Flush), 32'h1);
        chk("midflush.pre_pc",    if3.PCResult, 32'h204);
        #2 Reset = 1'b1;
        #1;
        chk("midflush.flush", 32'(if3.Flush), 32'h0);
        chk("midflush.pc",    if3.PCResult, 32'h0);
        chk("midflush.mis",   32'(if3.Misaligned), 32'h0);

        // Asynchronous reset while halted.
        do_reset();
        drive(mk_in(0, 0, 0, 0, 0, 0, 1));
        @(posedge Clk);
        #1 drive(idle);
        chk("midhalt.pre_valid", 32'(if1.Valid), 32'h0);
        #2 Reset = 1'b1;
        #1;
        chk("midhalt.valid", 32'(if1.Valid), 32'h1);
        chk("midhalt.pc",    if1.PCResult, 32'h0);

        do_reset();
        for (int c = 0; c < 400; c++) begin
            ri.stall = ($urandom_range(3) == 0);
            ri.br    = ($urandom_range(7) == 0);
            ri.j     = ($urandom_range(7) == 0);
            ri.exc   = ($urandom_range(15) == 0);
            ri.halt  = ($urandom_range(19) == 0);
            ri.bt    = rnd_tgt();
            ri.jt    = rnd_tgt();
            drive(ri);
            @(posedge Clk);
            #1;
            m1 = mstep(m1, ri, 1);
            m3 = mstep(m3, ri, 3);
            chk_mdl($sformatf("rnd%0d.d1", c), m1, if1.PCResult, if1.PCAddResult,
                    if1.Flush, if1.Valid, if1.Misaligned);
            chk_mdl($sformatf("rnd%0d.d3", c), m3, if3.PCResult, if3.PCAddResult,
                    if3.Flush, if3.Valid, if3.Misaligned);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter unit for the fetch stage. It holds the PC register and selects the next PC from reset vector, exception vector, branch target, jump target, hold (stall) or PC + INC. It generates a flush window after every redirect and provides a halt state. It sits between the hazard/branch logic and instruction memory, and supersedes the standalone PC incrementor.

Parameters:
WIDTH, 32, PC and target width in bits
INC, 4, increment added each sequential step (power of two)
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h8000_0180, PC value loaded on exception
FLUSH_CYCLES, 1, cycles Flush stays high after a redirect (1..7)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
Stall  in  1  hold PC (load-use or memory hazard)
BranchTaken  in  1  redirect to BranchTarget
BranchTarget  in  WIDTH  branch destination
Jump  in  1  redirect to JumpTarget
JumpTarget  in  WIDTH  jump destination
Exception  in  1  redirect to EXC_VECTOR
Halt  in  1  enter HALT state (e.g. syscall/break)
PCResult  out  WIDTH  current PC (registered)
PCAddResult  out  WIDTH  PCResult + INC (combinational from PC register)
Flush  out  1  squash younger fetched instructions
Valid  out  1  PCResult is a fetch to be issued
Misaligned  out  1  registered; set when a redirect target is not INC-aligned

Behaviour:
- Reset (async, high): PC = RESET_VECTOR; state = RUN; Flush = 0; Misaligned = 0; flush counter = 0. Valid = 1 in the first cycle after Reset deasserts. Reset mid-flush or mid-halt aborts immediately.
- States: RUN, FLUSH, HALT.
- Next-PC priority, evaluated on every rising edge outside HALT:
  Exception > BranchTaken > Jump > Stall > PC + INC.
- Redirects override Stall. A stalled cycle with BranchTaken=1 still loads BranchTarget.
- Any redirect (Exception, BranchTaken or Jump):
  - load the selected target;
  - state -> FLUSH;
  - flush counter = FLUSH_CYCLES - 1.
  Flush is high for exactly FLUSH_CYCLES cycles starting the cycle after the redirect edge.
- FLUSH: PC advances normally (Stall honoured). The counter decrements each cycle and the state returns to RUN when it reaches 0. A new redirect during FLUSH reloads the counter, so the flush window restarts.
- Misaligned target: if the target's low log2(INC) bits are nonzero, load EXC_VECTOR instead and set Misaligned for one cycle. The flush window is still taken. EXC_VECTOR itself is never checked.
- HALT:
  - Entered when Halt=1 with no redirect in the same cycle; PC holds.
  - Valid = 0 and Flush = 0 while halted.
  - Left only by Exception (-> EXC_VECTOR, FLUSH) or Reset. Branch, Jump and Stall are ignored in HALT.
  - Halt and a redirect in the same cycle: the redirect wins and Halt is dropped.
- Valid = (state == RUN) or (state == FLUSH and Flush == 0), i.e. Valid = !Flush && state != HALT.
- Arithmetic: PC + INC is computed modulo 2^WIDTH. 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no flag.
- Output latency: PC changes one edge after the selecting input. PCAddResult follows PCResult with zero cycles of latency.

Decomposition:
- Shared package pc_pkg:
  - state encoding (RUN=2'd0, FLUSH=2'd1, HALT=2'd2);
  - next-PC select encoding (SEL_INC, SEL_HOLD, SEL_BR, SEL_J, SEL_EXC);
  - default vector constants.
- One sub-module, pc_next_mux: combinational priority select plus alignment check, returning the next PC and the misaligned bit.
- The register, counter and state machine stay in pc_sequencer.

Test Plan:
- Reset, then 4 free cycles -> PCResult 0x0, 0x4, 0x8, 0xC; PCAddResult always PC+4; Valid=1; Flush=0.
- At PC=0x10, Stall=1 for 2 cycles -> PC holds at 0x10 for both; then 0x14.
- At PC=0x20, BranchTaken=1, BranchTarget=0x100, Jump=1, JumpTarget=0x200, Stall=1 -> PC=0x100 next cycle; Flush=1 and Valid=0 for 1 cycle; then PC 0x104 with Valid=1.
- Jump with JumpTarget=0x202 -> PC=0x8000_0180, Misaligned=1 for one cycle, Flush=1.
- Halt=1 at PC=0x40 -> PC frozen at 0x40, Valid=0 for 5 cycles despite Jump=1. Exception=1 then gives PC=0x8000_0180, Flush=1.
- PC forced to 0xFFFF_FFFC by BranchTarget -> next PC 0x0000_0000. Assert Reset mid-FLUSH (FLUSH_CYCLES=3) -> Flush=0 and PC=0x0 immediately, without waiting for a clock edge.
